// File: rtl/snn_inference_ctrl.sv
// Inference sequencer for the integrate-and-fire network: clear, stream timesteps, drain, argmax.
// Optional macro SNN_CTRL_COUNTS_OUT_EN exposes the live per-neuron spike counters on spike_counts.
module snn_inference_ctrl #(
  parameter int NUM_INPUTS       = 4,
  parameter int NUM_OUTPUTS      = 4,
  parameter int NUM_TIMESTEPS    = 16,
  parameter int RESET_CYCLES     = 2,
  parameter int DRAIN_CYCLES     = 1,
  parameter int CNT_WIDTH        = 8,
  parameter int WEIGHT_SIZE      = 32,
  parameter int LAYER_ADDR_WIDTH = 32,
  localparam int CLS_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [CLS_W-1:0]            class_out,
  output logic [CNT_WIDTH-1:0]        max_count,
  input  logic                        in_valid,
  input  logic [NUM_INPUTS-1:0]       in_spikes,
  output logic                        in_ready,
  output logic                        net_rst,
  output logic [NUM_INPUTS-1:0]       net_spike_in,
  input  logic [NUM_OUTPUTS-1:0]      net_spike_out,
  input  logic [LAYER_ADDR_WIDTH-1:0] host_addr,
  input  logic [WEIGHT_SIZE-1:0]      host_din,
  input  logic                        host_wen,
  output logic [WEIGHT_SIZE-1:0]      host_dout,
  output logic                        host_err,
  output logic [LAYER_ADDR_WIDTH-1:0] mem_addr,
  output logic [WEIGHT_SIZE-1:0]      mem_din,
  output logic                        mem_wen,
  input  logic [WEIGHT_SIZE-1:0]      mem_dout,
  output logic [2:0]                  state_dbg
`ifdef SNN_CTRL_COUNTS_OUT_EN
  ,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] spike_counts
`endif
);

  // Input handshake: a vector is consumed on any cycle where in_valid & in_ready;
  // in_ready is high exactly while the controller is in RUN.

  localparam int TS_W = $clog2(NUM_TIMESTEPS + 1);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam int DR_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [TS_W-1:0]      TS_LAST   = TS_W'(NUM_TIMESTEPS - 1);
  localparam logic [RC_W-1:0]      RC_LAST   = RC_W'(RESET_CYCLES - 1);
  localparam logic [DR_W-1:0]      DR_LAST   = DR_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CLS_W-1:0]     SCAN_LAST = CLS_W'(NUM_OUTPUTS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    ARGMAX = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state;
  logic [TS_W-1:0]      ts_cnt;
  logic [RC_W-1:0]      rc_cnt;
  logic [DR_W-1:0]      dr_cnt;
  logic [CLS_W-1:0]     scan_idx;
  logic [CLS_W-1:0]     best_idx;
  logic [CNT_WIDTH-1:0] best_val;
  logic [CNT_WIDTH-1:0] cnt [NUM_OUTPUTS];
  logic                 count_en;
  logic                 scan_gt;

  assign count_en     = (state == RUN) || (state == DRAIN);
  assign scan_gt      = cnt[scan_idx] > best_val;
  assign net_spike_in = (in_ready && in_valid) ? in_spikes : '0;
  assign state_dbg    = state;

  // Weight port is owned by the host except that writes are blocked mid-inference.
  assign mem_addr  = host_addr;
  assign mem_din   = host_din;
  assign host_dout = mem_dout;
  assign mem_wen   = host_wen & ~busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
      max_count <= '0;
      in_ready  <= 1'b0;
      net_rst   <= 1'b1;
      host_err  <= 1'b0;
      ts_cnt    <= '0;
      rc_cnt    <= '0;
      dr_cnt    <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
    end else begin
      host_err <= host_wen & busy;
      done     <= 1'b0;
      if (count_en) begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          if (net_spike_out[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          net_rst <= 1'b0;
          if (start) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            net_rst <= 1'b1;
            rc_cnt  <= '0;
            ts_cnt  <= '0;
            dr_cnt  <= '0;
            for (int i = 0; i < NUM_OUTPUTS; i++) cnt[i] <= '0;
          end
        end
        CLEAR: begin
          if (rc_cnt == RC_LAST) begin
            state    <= RUN;
            net_rst  <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            rc_cnt <= rc_cnt + 1'b1;
          end
        end
        RUN: begin
          if (in_valid) begin
            ts_cnt <= ts_cnt + 1'b1;
            if (ts_cnt == TS_LAST) begin
              in_ready <= 1'b0;
              scan_idx <= '0;
              best_idx <= '0;
              best_val <= '0;
              state    <= (DRAIN_CYCLES == 0) ? ARGMAX : DRAIN;
            end
          end
        end
        DRAIN: begin
          if (dr_cnt == DR_LAST) begin
            state <= ARGMAX;
          end else begin
            dr_cnt <= dr_cnt + 1'b1;
          end
        end
        ARGMAX: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (scan_gt) begin
            best_val <= cnt[scan_idx];
            best_idx <= scan_idx;
          end
          if (scan_idx == SCAN_LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            class_out <= scan_gt ? scan_idx : best_idx;
            max_count <= scan_gt ? cnt[scan_idx] : best_val;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNN_CTRL_COUNTS_OUT_EN
  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_counts
    assign spike_counts[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Randomized bench for snn_inference_ctrl: a timing/count reference model, a result scoreboard,
// and a weight memory model behind the mem port. A second instance uses 3-bit counters.
module tb_snn_inference_ctrl;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int T  = 16;
  localparam int R  = 2;
  localparam int D  = 1;

  localparam int PH_CLEAR = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_ARG   = 3;
  localparam int PH_DONE  = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          start, in_valid, host_wen;
  logic [NI-1:0] in_spikes;
  logic [NO-1:0] net_spike_out;
  logic [31:0]   host_addr, host_din, mem_dout;

  logic          busy, done, in_ready, net_rst, host_err, mem_wen;
  logic [1:0]    class_out;
  logic [7:0]    max_count;
  logic [NI-1:0] net_spike_in;
  logic [31:0]   host_dout, mem_addr, mem_din;
  logic [2:0]    state_dbg;

  logic          b3, d3, ir3, nr3, he3, mw3;
  logic [1:0]    cls3;
  logic [2:0]    max3, sd3;
  logic [NI-1:0] nsi3;
  logic [31:0]   hd3, ma3, md3;

  logic [31:0] tbmem [256];
  assign mem_dout = tbmem[mem_addr[7:0]];
  always @(posedge clk) if (mem_wen) tbmem[mem_addr[7:0]] <= mem_din;

  snn_inference_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .class_out(class_out), .max_count(max_count),
    .in_valid(in_valid), .in_spikes(in_spikes), .in_ready(in_ready),
    .net_rst(net_rst), .net_spike_in(net_spike_in), .net_spike_out(net_spike_out),
    .host_addr(host_addr), .host_din(host_din), .host_wen(host_wen),
    .host_dout(host_dout), .host_err(host_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout),
    .state_dbg(state_dbg)
  );

  snn_inference_ctrl #(.CNT_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .busy(b3), .done(d3),
    .class_out(cls3), .max_count(max3),
    .in_valid(in_valid), .in_spikes(in_spikes), .in_ready(ir3),
    .net_rst(nr3), .net_spike_in(nsi3), .net_spike_out(net_spike_out),
    .host_addr(host_addr), .host_din(host_din), .host_wen(host_wen),
    .host_dout(hd3), .host_err(he3),
    .mem_addr(ma3), .mem_din(md3), .mem_wen(mw3), .mem_dout(mem_dout),
    .state_dbg(sd3)
  );

  // scoreboard: {class, max_count} of the 8-bit instance
  logic [9:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner from raw window spike sums: saturate to the counter width, lowest index wins ties.
  function automatic logic [9:0] ref_result(input int sums [NO], input int w);
    int best, cls, v, cap;
    cap  = (1 << w) - 1;
    best = -1;
    cls  = 0;
    for (int i = 0; i < NO; i++) begin
      v = (sums[i] > cap) ? cap : sums[i];
      if (v > best) begin
        best = v;
        cls  = i;
      end
    end
    return {cls[1:0], best[7:0]};
  endfunction

  // Network stand-in; w counts counted cycles (RUN+DRAIN) already elapsed.
  function automatic logic [NO-1:0] net_model(input int mode, input bit in_win, input int w);
    logic [NO-1:0] r;
    r = NO'($urandom);
    case (mode)
      0: r = {1'b0, 1'b1, in_win && (w % 2 == 0), 1'b0};
      1: if (in_win) r = {w < 5, w < 4, w < 5, w < 3};
      2: r[0] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  // One inference from the current (IDLE) cycle. Returns the cycle index at which the DUT showed
  // done (edge 0 = start sampled), or -1. abort_k >= 0 drops rst in that cycle instead.
  task automatic run_inf(input int mode, input int stall_mode, input int wen_mode,
                         input int abort_k, output int dk);
    int acc, run_end, w, stall_left, ph;
    int sums [NO];
    logic exp_err, in_win;
    logic [9:0] exp, exp3;
    logic [NI-1:0] exp_nsi;
    acc = 0; run_end = -1; w = 0; stall_left = 3; exp_err = 1'b0; dk = -1;
    for (int i = 0; i < NO; i++) sums[i] = 0;
    start = 1'b1;
    host_wen = 1'b0;
    tick();
    for (int k = 0; k < 200; k++) begin
      if (k < R) ph = PH_CLEAR;
      else if (run_end < 0) ph = PH_RUN;
      else if (k < run_end + D) ph = PH_DRAIN;
      else if (k < run_end + D + NO) ph = PH_ARG;
      else ph = PH_DONE;
      in_win = (ph == PH_RUN) || (ph == PH_DRAIN);

      start = 1'($urandom_range(0, 1));
      in_spikes = NI'($urandom);
      if (ph == PH_RUN) begin
        case (stall_mode)
          1: in_valid = !(acc == 8 && stall_left > 0);
          2: in_valid = ($urandom_range(0, 3) != 0);
          default: in_valid = 1'b1;
        endcase
      end else begin
        in_valid = 1'($urandom_range(0, 1));
      end
      net_spike_out = net_model(mode, in_win, w);
      host_addr = 32'h10;
      host_din  = $urandom;
      host_wen  = (wen_mode != 0) && ($urandom_range(0, 2) == 0);
      #1;
      exp_nsi = (ph == PH_RUN && in_valid) ? in_spikes : '0;
      check("busy", busy, 1'b1);
      check("net_rst", net_rst, ph == PH_CLEAR);
      check("in_ready", in_ready, ph == PH_RUN);
      check("net_spike_in", net_spike_in, exp_nsi);
      check("done", done, ph == PH_DONE);
      check("mem_wen_busy", mem_wen, 1'b0);
      check("host_err", host_err, exp_err);
      if (done && dk < 0) dk = k;

      if (in_win) begin
        for (int i = 0; i < NO; i++) sums[i] += int'(net_spike_out[i]);
        w++;
      end
      if (ph == PH_RUN) begin
        if (in_valid) begin
          acc++;
          if (acc == T) run_end = k + 1;
        end else if (stall_mode == 1) begin
          stall_left--;
        end
      end
      if (ph == PH_ARG && k == run_end + D) exp_q.push_back(ref_result(sums, 8));
      exp_err = host_wen;

      if (ph == PH_DONE) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 1'b1, 1'b0);
        end else begin
          exp = exp_q.pop_front();
          check("class_out", class_out, exp[9:8]);
          check("max_count", max_count, exp[7:0]);
        end
        exp3 = ref_result(sums, 3);
        check("class_out_w3", cls3, exp3[9:8]);
        check("max_count_w3", max3, exp3[2:0]);
        break;
      end

      if (k == abort_k) begin
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_net_rst", net_rst, 1'b1);
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_class", class_out, 2'd0);
        check("abort_max", max_count, 8'd0);
        check("abort_host_err", host_err, 1'b0);
        start = 1'b0;
        host_wen = 1'b0;
        tick();
        check("abort_done_hold", done, 1'b0);
        check("abort_busy_hold", busy, 1'b0);
        #3 rst = 1'b1;
        tick();
        check("abort_rel_net_rst", net_rst, 1'b0);
        return;
      end
      tick();
    end
    if (dk < 0) check("done_timeout", 1'b0, 1'b1);
    exp = {class_out, max_count};
    tick();
    start = 1'b0;
    host_wen = 1'b0;
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_in_ready", in_ready, 1'b0);
    check("idle_net_rst", net_rst, 1'b0);
    check("idle_host_err", host_err, exp_err);
    check("idle_hold", {class_out, max_count}, exp);
  endtask

  task automatic host_write_read();
    host_addr = 32'h10;
    host_din  = 32'hDEADBEEF;
    host_wen  = 1'b1;
    #1;
    check("idle_mem_wen", mem_wen, 1'b1);
    check("mem_addr", mem_addr, 32'h10);
    check("mem_din", mem_din, 32'hDEADBEEF);
    tick();
    host_wen = 1'b0;
    host_din = 32'h0;
    #1;
    check("idle_host_err_w", host_err, 1'b0);
    check("host_dout", host_dout, 32'hDEADBEEF);
  endtask

  initial begin
    int dk;
    for (int i = 0; i < 256; i++) tbmem[i] = 32'h0;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_spikes = '0; net_spike_out = '0;
    host_addr = '0; host_din = '0; host_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_class", class_out, 2'd0);
    check("rst_max", max_count, 8'd0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_net_rst", net_rst, 1'b1);
    check("rst_host_err", host_err, 1'b0);
    #3 rst = 1'b1;
    tick();
    check("rel_net_rst", net_rst, 1'b0);

    run_inf(0, 0, 0, -1, dk);
    check("t1_latency", dk, 23);
    check("t1_class", class_out, 2'd2);
    check("t1_max", max_count, 8'd17);

    run_inf(1, 0, 0, -1, dk);
    check("tie_class", class_out, 2'd1);
    check("tie_max", max_count, 8'd5);

    run_inf(0, 1, 0, -1, dk);
    check("stall_latency", dk, 26);

    run_inf(2, 0, 0, -1, dk);
    check("sat_max_w3", max3, 3'd7);
    check("sat_class_w3", cls3, 2'd0);
    check("sat_max_w8", max_count, 8'd17);

    host_write_read();
    run_inf(3, 2, 1, -1, dk);
    host_addr = 32'h10;
    #1;
    check("busy_write_dropped", host_dout, 32'hDEADBEEF);

    run_inf(3, 0, 0, 8, dk);
    run_inf(0, 0, 0, -1, dk);
    check("post_abort_latency", dk, 23);
    check("post_abort_class", class_out, 2'd2);
    check("post_abort_max", max_count, 8'd17);

    for (int n = 0; n < 6; n++) run_inf(3, 2, 1, -1, dk);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_inference_ctrl.md
# snn_inference_ctrl

Sequencing controller for the recurrent integrate-and-fire network. It clears the network, streams one input spike vector per timestep for a fixed number of timesteps, and counts output spikes per neuron. It then resolves the winning class with a sequential argmax. It also owns the network's weight-memory port, passing host accesses through only while no inference is running.

## Interface
- `NUM_INPUTS`, 4, input spike vector width
- `NUM_OUTPUTS`, 4, number of network output neurons (≥2)
- `NUM_TIMESTEPS`, 16, accepted input vectors per inference (≥1)
- `RESET_CYCLES`, 2, cycles `net_rst` is held high in CLEAR (≥1)
- `DRAIN_CYCLES`, 1, zero-input cycles after the last timestep that still count spikes (≥0)
- `CNT_WIDTH`, 8, per-neuron spike counter width
- `WEIGHT_SIZE`, 32, weight data width
- `LAYER_ADDR_WIDTH`, 32, weight address width
- `clk` in 1: system clock
- `rst` in 1: asynchronous reset, active-low
- `start` in 1: begin inference; sampled only in IDLE
- `busy` out 1: high from the cycle after `start` until DONE completes
- `done` out 1: one-cycle pulse when `class_out` is updated
- `class_out` out max(1,$clog2(NUM_OUTPUTS)): winning neuron index
- `max_count` out CNT_WIDTH: spike count of the winner
- `in_valid` in 1: input spike vector valid
- `in_spikes` in NUM_INPUTS: input spike vector for one timestep
- `in_ready` out 1: vector accepted on `in_valid & in_ready`
- `net_rst` out 1: network reset, active-high, synchronous to `clk`
- `net_spike_in` out NUM_INPUTS: network spike input
- `net_spike_out` in NUM_OUTPUTS: network spike output
- `host_addr` in LAYER_ADDR_WIDTH, `host_din` in WEIGHT_SIZE, `host_wen` in 1, `host_dout` out WEIGHT_SIZE: host weight port
- `host_err` out 1: one-cycle pulse, write rejected
- `mem_addr` out LAYER_ADDR_WIDTH, `mem_din` out WEIGHT_SIZE, `mem_wen` out 1, `mem_dout` in WEIGHT_SIZE: network weight port

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, ARGMAX, DONE.
- IDLE:
  - `start` high moves to CLEAR and zeroes all spike counters, the timestep counter and the drain counter.
- CLEAR:
  - `net_rst`=1 for exactly RESET_CYCLES cycles, then move to RUN.
- RUN:
  - `in_ready`=1.
  - `net_spike_in` = `in_valid ? in_spikes : 0`, combinational.
  - Each accepted vector increments the timestep counter.
  - Stall cycles drive zeros and do not advance the timestep counter.
  - The cycle that accepts vector NUM_TIMESTEPS moves to DRAIN, or to ARGMAX if DRAIN_CYCLES=0.
- DRAIN:
  - `net_spike_in`=0 for DRAIN_CYCLES cycles, then move to ARGMAX.
- Spike counting:
  - In RUN and DRAIN, every cycle, count[i] increments when `net_spike_out[i]`=1.
  - Counters saturate at 2^CNT_WIDTH−1.
- ARGMAX:
  - Scans one neuron per cycle, index 0..NUM_OUTPUTS−1, keeping the running best.
  - Replace only on a strictly greater count, so ties resolve to the lowest index.
- DONE:
  - Latch `class_out` and `max_count`, pulse `done`, return to IDLE.
  - Both outputs hold until the next DONE.
- `start` outside IDLE is ignored.
- Memory arbitration:
  - `mem_addr`, `mem_din` and `host_dout` are direct passthroughs at all times.
  - `mem_wen` = `host_wen & ~busy`.
  - `host_wen` while `busy` is dropped and pulses `host_err` in the following cycle.
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `class_out`=0, `max_count`=0, `in_ready`=0, `net_rst`=1, `host_err`=0, counters 0.
  - `net_rst` returns to 0 on the first clock after reset release, in IDLE.
- Reset mid-inference aborts immediately: all outputs take their reset values and no `done` is generated.

## Timing
- `start` sampled high at edge 0: `busy`=1 and `net_rst`=1 from edge 0 through edge RESET_CYCLES.
- `in_ready` rises after edge RESET_CYCLES.
- With no stalls, `done` is high in the cycle after edge RESET_CYCLES+NUM_TIMESTEPS+DRAIN_CYCLES+NUM_OUTPUTS.
- Each stall cycle in RUN adds one cycle to that latency.
- `busy` falls in the same edge that ends `done`. A new `start` is accepted in the following cycle.
- `net_spike_out` sampled in the last DRAIN cycle is counted. Spikes in ARGMAX are ignored.

## Configuration
- `SNN_CTRL_COUNTS_OUT_EN`:
  - Defined: adds output `spike_counts` [NUM_OUTPUTS*CNT_WIDTH−1:0], neuron i at bits [i*CNT_WIDTH +: CNT_WIDTH]. It shows the live counters, and the final values are valid from DONE until the next `start`.
  - Undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Default parameters, `in_valid` tied high, network model spikes neuron 2 on every timestep and neuron 1 on alternate timesteps → `done` in the cycle after edge 23; `class_out`=2, `max_count`=17 (16 + 1 drain).
- Neurons 1 and 3 each spike 5 times, all others fewer → `class_out`=1 (lowest-index tie-break), `max_count`=5.
- `in_valid` low for 3 cycles mid-RUN → exactly 16 vectors accepted, `net_spike_in`=0 during stalls, `done` 3 cycles later than the no-stall case.
- Neuron 0 spikes every cycle with CNT_WIDTH=3 → `max_count`=7 (saturated), no wrap.
- `host_wen` pulsed while `busy` → `mem_wen` stays 0 and `host_err` pulses once. In IDLE, a write of 0xDEADBEEF to addr 0x10 followed by a read → `host_dout`=0xDEADBEEF.
- Drop `rst` during RUN → next cycle `busy`=0, `net_rst`=1, `in_ready`=0, no `done`. After reset release, `start` runs a full inference normally.
